mux_key_table: RTL and testbench

//  Runtime-programmable successor to the combinational key/data mux.

---
 rtl/mux_key_table.sv | 123 ++++++++++++
 tb/tb_mux_key_table.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_key_table.sv
`default_nettype none
// mux_key_table: runtime-programmable {valid,key,data} table answered through a 1-stage valid/ready lookup pipe.
// Optional hit/miss counters are built when MUX_KEY_TABLE_STATS_EN is defined.  Rev 1.0
module mux_key_table #(
  parameter int NR_KEY      = 4,
  parameter int KEY_LEN     = 4,
  parameter int DATA_LEN    = 32,
  parameter int HAS_DEFAULT = 1,
  localparam int IDX_W      = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                clr,
  input  logic                lk_valid,
  output logic                lk_ready,
  input  logic [KEY_LEN-1:0]  lk_key,
  input  logic [DATA_LEN-1:0] lk_default,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_LEN-1:0] rsp_data,
  output logic                rsp_hit,
  output logic [IDX_W-1:0]    rsp_idx,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt
);

  logic [NR_KEY-1:0]   entry_valid;
  logic [KEY_LEN-1:0]  entry_key  [NR_KEY];
  logic [DATA_LEN-1:0] entry_data [NR_KEY];

  logic                match_hit;
  logic [IDX_W-1:0]    match_idx;
  logic [DATA_LEN-1:0] match_data;
  logic                accept;

  assign lk_ready = !rsp_valid || rsp_ready;
  assign accept   = lk_valid && lk_ready;

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    match_hit  = 1'b0;
    match_idx  = '0;
    match_data = '0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (entry_valid[i] && (entry_key[i] == lk_key)) begin
        match_hit  = 1'b1;
        match_idx  = IDX_W'(i);
        match_data = entry_data[i];
      end
    end
  end

  // Out-of-range wr_idx matches no entry, so such writes fall through untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_valid <= '0;
      for (int i = 0; i < NR_KEY; i++) begin
        entry_key[i]  <= '0;
        entry_data[i] <= '0;
      end
    end else if (clr) begin
      entry_valid <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          entry_valid[i] <= 1'b1;
          entry_key[i]   <= wr_key;
          entry_data[i]  <= wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_idx   <= '0;
      rsp_data  <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_hit   <= match_hit;
      rsp_idx   <= match_idx;
      if (match_hit) begin
        rsp_data <= match_data;
      end else begin
        rsp_data <= (HAS_DEFAULT != 0) ? lk_default : '0;
      end
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef MUX_KEY_TABLE_STATS_EN
  logic [31:0] hit_q;
  logic [31:0] miss_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (accept) begin
      if (match_hit && (hit_q != 32'hFFFF_FFFF)) begin
        hit_q <= hit_q + 32'd1;
      end else if (!match_hit && (miss_q != 32'hFFFF_FFFF)) begin
        miss_q <= miss_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_key_table.sv
`default_nettype none
// tb_mux_key_table: directed and random lookups checked against a table/queue reference model.
module tb_mux_key_table;
  localparam int NR = 5;   // non power of two so wr_idx = NR is representable
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_idx = '0;
  logic [3:0]    wr_key = '0;
  logic [31:0]   wr_data = '0;
  logic          clr = 1'b0;
  logic          lk_valid = 1'b0;
  logic          lk_ready;
  logic [3:0]    lk_key = '0;
  logic [31:0]   lk_default = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_data;
  logic          rsp_hit;
  logic [IW-1:0] rsp_idx;
  logic [31:0]   hit_cnt;
  logic [31:0]   miss_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          m_v [NR];
  logic [3:0]  m_k [NR];
  logic [31:0] m_d [NR];
  bit          m_rv;
  bit          m_hit;
  int          m_idx;
  logic [31:0] m_data;
  longint      m_hits, m_misses;

  mux_key_table #(.NR_KEY(NR), .KEY_LEN(4), .DATA_LEN(32), .HAS_DEFAULT(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .wr_data(wr_data), .clr(clr), .lk_valid(lk_valid), .lk_ready(lk_ready),
    .lk_key(lk_key), .lk_default(lk_default), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
    .rsp_idx(rsp_idx), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The first valid entry holding the key wins.
  task automatic model_lookup(input logic [3:0] k, output bit h, output int idx, output logic [31:0] d);
    h = 0; idx = 0; d = lk_default;
    for (int i = 0; i < NR; i++) begin
      if (!h && m_v[i] && m_k[i] == k) begin
        h = 1; idx = i; d = m_d[i];
      end
    end
  endtask

  // One clock: check lk_ready, step the model on the edge, check registered outputs.
  task automatic cycle();
    bit          acc, h;
    int          idx;
    logic [31:0] d;
    #1;
    check("lk_ready", lk_ready, (!m_rv || rsp_ready));
    acc = lk_valid && (!m_rv || rsp_ready);
    model_lookup(lk_key, h, idx, d);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NR; i++) begin m_v[i] = 0; m_k[i] = 0; m_d[i] = 0; end
      m_rv = 0; m_hit = 0; m_idx = 0; m_data = 0; m_hits = 0; m_misses = 0;
    end else begin
      if (acc) begin
        m_rv = 1; m_hit = h; m_idx = idx; m_data = d;
        if (h) m_hits = (m_hits < 64'hFFFF_FFFF) ? m_hits + 1 : m_hits;
        else   m_misses = (m_misses < 64'hFFFF_FFFF) ? m_misses + 1 : m_misses;
      end else if (rsp_ready) begin
        m_rv = 0;
      end
      if (clr) begin
        for (int i = 0; i < NR; i++) m_v[i] = 0;
      end else if (wr_en && int'(wr_idx) < NR) begin
        m_v[wr_idx] = 1; m_k[wr_idx] = wr_key; m_d[wr_idx] = wr_data;
      end
    end
    @(negedge clk);
    check("rsp_valid", rsp_valid, m_rv);
    check("rsp_hit", rsp_hit, m_hit);
    check("rsp_idx", rsp_idx, m_idx);
    check("rsp_data", rsp_data, m_data);
`ifdef MUX_KEY_TABLE_STATS_EN
    check("hit_cnt", hit_cnt, m_hits);
    check("miss_cnt", miss_cnt, m_misses);
`else
    check("hit_cnt", hit_cnt, 0);
    check("miss_cnt", miss_cnt, 0);
`endif
  endtask

  task automatic idle();
    wr_en = 0; clr = 0; lk_valid = 0; rst = 0;
  endtask

  task automatic write(input int idx, input logic [3:0] k, input logic [31:0] d);
    wr_en = 1; wr_idx = IW'(idx); wr_key = k; wr_data = d;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin m_v[i] = 0; m_k[i] = 0; m_d[i] = 0; end
    m_rv = 0; m_hit = 0; m_idx = 0; m_data = 0; m_hits = 0; m_misses = 0;
    @(negedge clk);
    rst = 1; cycle(); cycle();
    idle(); rsp_ready = 1;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);

    // Miss after reset returns the default
    lk_valid = 1; lk_key = 4'd3; lk_default = 32'hDEAD; cycle();
    check("t1_hit", rsp_hit, 0);
    check("t1_data", rsp_data, 32'hDEAD);
    idle(); cycle();
    check("t1_drain", rsp_valid, 0);

    // Duplicate keys: lowest index reported
    write(1, 4'd5, 32'h1111); cycle();
    write(3, 4'd5, 32'h3333); cycle();
    idle(); lk_valid = 1; lk_key = 4'd5; cycle();
    check("t2_hit", rsp_hit, 1);
    check("t2_idx", rsp_idx, 1);
    check("t2_data", rsp_data, 32'h1111);
    idle(); cycle();

    // Backpressure holds the first response; both delivered in order
    rsp_ready = 0; lk_valid = 1; lk_key = 4'd5; cycle();
    lk_key = 4'd7;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t3_stall_ready", lk_ready, 0);
      check("t3_stall_data", rsp_data, 32'h1111);
    end
    rsp_ready = 1; cycle();
    check("t3_second_hit", rsp_hit, 0);
    check("t3_second_valid", rsp_valid, 1);
    idle(); cycle();

    // Lookup in the write cycle sees the old table
    write(2, 4'd9, 32'h2222); lk_valid = 1; lk_key = 4'd9; cycle();
    check("t4_same_cycle_hit", rsp_hit, 0);
    wr_en = 0; cycle();
    check("t4_next_hit", rsp_hit, 1);
    check("t4_next_idx", rsp_idx, 2);
    idle(); cycle();

    // clr beats a simultaneous write; out-of-range write is ignored
    clr = 1; write(0, 4'd4, 32'h4444); cycle();
    idle(); lk_valid = 1; lk_key = 4'd4; cycle();
    check("t5_clr_wins", rsp_hit, 0);
    idle(); write(NR, 4'd4, 32'h5555); cycle();
    idle(); lk_valid = 1; lk_key = 4'd4; cycle();
    check("t5_oob_ignored", rsp_hit, 0);
    idle(); lk_valid = 1; lk_key = 4'd5; cycle();
    check("t5_invalid_no_match", rsp_hit, 0);

    // Counters: 3 hits, 2 misses from a fresh reset
    idle(); rst = 1; cycle();
    idle(); write(0, 4'd6, 32'h6666); cycle();
    idle(); lk_valid = 1;
    lk_key = 4'd6; cycle(); cycle(); cycle();
    lk_key = 4'd1; cycle(); cycle();
    idle(); cycle();
`ifdef MUX_KEY_TABLE_STATS_EN
    check("t6_hits", hit_cnt, 3);
    check("t6_misses", miss_cnt, 2);
`else
    check("t6_hits", hit_cnt, 0);
    check("t6_misses", miss_cnt, 0);
`endif
    rsp_ready = 0; lk_valid = 1; cycle();
    idle(); rst = 1; cycle();
    check("t6_rst_drops", rsp_valid, 0);
    check("t6_rst_cnt", hit_cnt, 0);

    // Random traffic
    idle();
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom_range(0, 99) == 0);
      clr        = ($urandom_range(0, 19) == 0);
      wr_en      = ($urandom_range(0, 3) == 0);
      wr_idx     = IW'($urandom_range(0, 7));
      wr_key     = 4'($urandom_range(0, 7));
      wr_data    = $urandom;
      lk_valid   = ($urandom_range(0, 9) < 7);
      lk_key     = 4'($urandom_range(0, 7));
      lk_default = $urandom;
      rsp_ready  = ($urandom_range(0, 9) < 6);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
